// File: rtl/counter_slot_pkg.sv
// Shared types and default sizing for the counter slot arbiter.
// Imported by the arbiter top and its round-robin picker.
package counter_slot_pkg;

   typedef enum logic [1:0] {
      IDLE,
      COUNT,
      DONE
   } slot_state_t;

   localparam int NUM_REQ_DEF = 4;
   localparam int CNT_W_DEF   = 4;

endpackage

// File: rtl/counter_slot_arbiter_rr_picker.sv
// Combinational round-robin selector: returns the first active request
// found after last_owner_i, wrapping modulo NUM_REQ, as one-hot plus index.
module rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   last_owner_i,
   output logic [NUM_REQ-1:0] pick_o,
   output logic [IDX_W-1:0]   pick_idx_o,
   output logic               valid_o
);

   always_comb begin : search
      logic [IDX_W-1:0] idx;
      // NOTE: every output gets a default before the loop so no path leaves
      // a value unassigned, which would otherwise infer a latch.
      pick_o     = '0;
      pick_idx_o = '0;
      valid_o    = 1'b0;
      idx        = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         idx = IDX_W'((int'(last_owner_i) + off) % NUM_REQ);
         if (!valid_o && req_i[idx]) begin
            valid_o     = 1'b1;
            pick_o[idx] = 1'b1;
            pick_idx_o  = idx;
         end
      end
   end

endmodule

// File: rtl/counter_slot_arbiter.sv
// Shares one up-counter among NUM_REQ requesters: grants round-robin, counts
// 0..len, pulses done for the owner. All outputs are registered.
module counter_slot_arbiter
   import counter_slot_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ-1:0][CNT_W-1:0]  len,
   output logic [NUM_REQ-1:0]             grant,
   output logic                           busy,
   output logic [CNT_W-1:0]               count,
   output logic [NUM_REQ-1:0]             done
);

   localparam int IDX_W = $clog2(NUM_REQ);

   slot_state_t        state_q;
   logic [IDX_W-1:0]   owner_q;
   logic [IDX_W-1:0]   last_owner_q;
   logic [CNT_W-1:0]   len_q;
   logic [CNT_W-1:0]   count_q;
   logic [NUM_REQ-1:0] grant_q;
   logic [NUM_REQ-1:0] done_q;
   logic               busy_q;

   logic [NUM_REQ-1:0] pick_oh;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_valid;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_picker (
      .req_i        (req),
      .last_owner_i (last_owner_q),
      .pick_o       (pick_oh),
      .pick_idx_o   (pick_idx),
      .valid_o      (pick_valid)
   );

   // NOTE: state and outputs are flops, so they use non-blocking assignments;
   // every register reads its pre-edge value regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_q      <= '0;
         last_owner_q <= IDX_W'(NUM_REQ - 1);
         len_q        <= '0;
         count_q      <= '0;
         grant_q      <= '0;
         done_q       <= '0;
         busy_q       <= 1'b0;
      end else begin
         done_q <= '0;
         case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  state_q      <= COUNT;
                  owner_q      <= pick_idx;
                  last_owner_q <= pick_idx;
                  len_q        <= len[pick_idx];
                  count_q      <= '0;
                  grant_q      <= pick_oh;
                  busy_q       <= 1'b1;
               end
            end
            COUNT: begin
               // Abort wins over completion: a dropped request never earns done.
               if (!req[owner_q]) begin
                  state_q <= IDLE;
                  count_q <= '0;
                  grant_q <= '0;
                  busy_q  <= 1'b0;
               end else if (count_q == len_q) begin
                  state_q <= DONE;
                  done_q  <= grant_q;
               end else begin
                  count_q <= count_q + CNT_W'(1);
               end
            end
            DONE: begin
               state_q <= IDLE;
               count_q <= '0;
               grant_q <= '0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               count_q <= '0;
               grant_q <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign grant = grant_q;
   assign busy  = busy_q;
   assign count = count_q;
   assign done  = done_q;

endmodule

// File: tb/tb_counter_slot_arbiter.sv
// Directed plus randomized bench for counter_slot_arbiter; a slot-level
// reference model (owner, length, elapsed cycles) predicts every output.
module tb_counter_slot_arbiter;

   localparam int NUM_REQ = 4;
   localparam int CNT_W   = 4;

   logic                          clk;
   logic                          reset;
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ-1:0][CNT_W-1:0] len;
   logic [NUM_REQ-1:0]            grant;
   logic                          busy;
   logic [CNT_W-1:0]              count;
   logic [NUM_REQ-1:0]            done;

   int n_cmp = 0;
   int n_mis = 0;

   // Reference model: owner (-1 when idle), slot length, cycles since grant.
   int m_owner = -1;
   int m_last  = NUM_REQ - 1;
   int m_len   = 0;
   int m_t     = 0;

   counter_slot_arbiter #(
      .NUM_REQ (NUM_REQ),
      .CNT_W   (CNT_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .len   (len),
      .grant (grant),
      .busy  (busy),
      .count (count),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_last  = NUM_REQ - 1;
      m_len   = 0;
      m_t     = 0;
   endtask

   // Applies one clock edge of slot rules, using the inputs seen at that edge.
   task automatic model_update();
      bit found;
      int k;
      found = 0;
      if (reset) begin
         model_reset();
      end else if (m_owner < 0) begin
         for (int off = 1; off <= NUM_REQ; off++) begin
            k = (m_last + off) % NUM_REQ;
            if (!found && req[k]) begin
               found   = 1;
               m_owner = k;
               m_last  = k;
               m_len   = int'(len[k]);
               m_t     = 0;
            end
         end
      end else if (m_t <= m_len) begin
         if (!req[m_owner]) m_owner = -1;
         else m_t++;
      end else begin
         m_owner = -1;
      end
   endtask

   task automatic chk_all(input string tag);
      logic [31:0] e_grant, e_count, e_done, e_busy;
      e_grant = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
      e_busy  = (m_owner >= 0) ? 32'd1 : 32'd0;
      e_count = (m_owner < 0) ? 32'd0 : ((m_t > m_len) ? 32'(m_len) : 32'(m_t));
      e_done  = (m_owner >= 0 && m_t == m_len + 1) ? (32'd1 << m_owner) : 32'd0;
      chk({tag, ".grant"}, 32'(grant), e_grant);
      chk({tag, ".busy"},  32'(busy),  e_busy);
      chk({tag, ".count"}, 32'(count), e_count);
      chk({tag, ".done"},  32'(done),  e_done);
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_update();
      #1;
      chk_all(tag);
   endtask

   task automatic idle_out(input string tag);
      req = '0;
      repeat (3) step(tag);
   endtask

   initial begin
      int cnt_exp [5] = '{0, 1, 2, 3, 3};
      int order   [5] = '{0, 1, 2, 3, 0};
      logic [NUM_REQ-1:0] flip;

      reset = 1'b1;
      req   = '0;
      len   = '0;
      model_reset();
      #1;
      chk_all("por");
      step("por_hold");
      reset = 1'b0;
      step("por_idle");

      // Reset mid-count, then req[0] must win after reset.
      req    = 4'b0010;
      len[1] = 4'd5;
      for (int c = 1; c <= 4; c++) step("rst_cnt");
      chk("rst_cnt3", 32'(count), 32'd3);
      reset = 1'b1;
      #1;
      model_reset();
      chk_all("rst_async");
      chk("rst_async_grant", 32'(grant), 32'd0);
      step("rst_hold");
      reset  = 1'b0;
      req    = 4'b0011;
      len[0] = 4'd2;
      len[1] = 4'd2;
      step("rst_rel");
      chk("rst_first_grant", 32'(grant), 32'b0001);
      idle_out("rst_idle");

      // Single slot on requester 2, len 3.
      req    = 4'b0100;
      len[2] = 4'd3;
      for (int c = 1; c <= 5; c++) begin
         step("single");
         chk("single_grant", 32'(grant), 32'b0100);
         chk("single_count", 32'(count), 32'(cnt_exp[c-1]));
         chk("single_done",  32'(done),  (c == 5) ? 32'b0100 : 32'd0);
      end
      req = '0;
      step("single_end");
      chk("single_idle", 32'(grant), 32'd0);
      step("single_idle2");

      // Contention with every requester held, all len 1.
      reset = 1'b1;
      #1;
      model_reset();
      step("cont_rst");
      reset = 1'b0;
      step("cont_rst_idle");
      req = 4'b1111;
      len = '{4'd1, 4'd1, 4'd1, 4'd1};
      for (int c = 1; c <= 17; c++) begin
         step("cont");
         if ((c - 1) % 4 == 0)
            chk("cont_order", 32'(grant), 32'd1 << order[(c - 1) / 4]);
      end
      idle_out("cont_idle");

      // Zero length: done at cycle 2 with count 0.
      req    = 4'b0010;
      len[1] = 4'd0;
      step("len0");
      step("len0");
      chk("len0_done",  32'(done),  32'b0010);
      chk("len0_count", 32'(count), 32'd0);
      idle_out("len0_idle");

      // Maximum length: done at cycle 17 with count 15, no wrap.
      req    = 4'b0100;
      len[2] = 4'd15;
      for (int c = 1; c <= 17; c++) step("lenmax");
      chk("lenmax_done",  32'(done),  32'b0100);
      chk("lenmax_count", 32'(count), 32'd15);
      idle_out("lenmax_idle");

      // Abort: req[3] dropped at count 4, pending req[0] served next.
      req    = 4'b1001;
      len[3] = 4'd8;
      len[0] = 4'd1;
      step("abort");
      chk("abort_grant3", 32'(grant), 32'b1000);
      for (int c = 2; c <= 5; c++) step("abort");
      chk("abort_cnt4", 32'(count), 32'd4);
      req = 4'b0001;
      step("abort_drop");
      chk("abort_grant0", 32'(grant), 32'd0);
      chk("abort_count0", 32'(count), 32'd0);
      chk("abort_nodone", 32'(done),  32'd0);
      step("abort_next");
      chk("abort_regrant", 32'(grant), 32'b0001);
      idle_out("abort_idle");

      // len change mid-slot is ignored.
      req    = 4'b0010;
      len[1] = 4'd2;
      step("lenchg");
      len[1] = 4'd9;
      for (int c = 2; c <= 4; c++) step("lenchg");
      chk("lenchg_done",  32'(done),  32'b0010);
      chk("lenchg_count", 32'(count), 32'd2);
      idle_out("lenchg_idle");

      // Randomized traffic: sticky requests with occasional toggles.
      for (int c = 0; c < 600; c++) begin
         flip = '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            if ($urandom_range(7) == 0) flip[i] = 1'b1;
            len[i] = CNT_W'($urandom_range(5));
         end
         if ($urandom_range(15) == 0) len[$urandom_range(NUM_REQ - 1)] = '1;
         req = req ^ flip;
         step("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
